// File: rtl/calc_op_sequencer.sv
// ----------------------------------------------------------------------------
// calc_op_sequencer
//   Command-driven sequencer for the calculator datapath (regA, regB, B-operand
//   mux, ALU, regC). Commands arrive over a valid/ready port and wait in a small
//   FIFO. A five-state FSM drives the datapath load/select/op controls for each
//   command. The regC result is returned over a valid/ready response port.
//
// Optional feature macro: CALC_SEQ_STATS_EN
//   When defined, the stat_done_o port is added. It is an 8-bit wrapping count
//   of completed responses.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   cmd_valid_i    command present
//   cmd_ready_o    FIFO not full
//   cmd_op_i       ALU opcode
//   cmd_a_i        operand A
//   cmd_b_i        operand B (ignored when cmd_chain_i=1)
//   cmd_chain_i    1: B operand is current regC, regB not reloaded
//   dp_dados_o     data bus to regA/regB
//   dp_enA_o       regA load enable
//   dp_enB_o       regB load enable
//   dp_sel_o       B-mux select (0=regB, 1=regC)
//   dp_op_o        ALU opcode
//   dp_op_reg_o    regC control (00 hold, 01 load ALU result)
//   dp_result_i    regC value
//   rsp_valid_o    result available
//   rsp_ready_i    consumer accepts result
//   rsp_result_o   result (regC) while rsp_valid_o
//   busy_o         FSM not idle or FIFO non-empty
//   state_o        FSM state code (debug)
//   stat_done_o    completed-response count (CALC_SEQ_STATS_EN only)
// ----------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int OP_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic              cmd_chain_i,
  output logic [DATA_W-1:0] dp_dados_o,
  output logic              dp_enA_o,
  output logic              dp_enB_o,
  output logic              dp_sel_o,
  output logic [OP_W-1:0]   dp_op_o,
  output logic [1:0]        dp_op_reg_o,
  input  logic [DATA_W:0]   dp_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W:0]   rsp_result_o,
  output logic              busy_o,
  output logic [2:0]        state_o
`ifdef CALC_SEQ_STATS_EN
  ,
  output logic [7:0]        stat_done_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = OP_W + 2 * DATA_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // FIFO storage and pointers
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_s, pop_s, empty_s, full_s;
  logic [ENT_W-1:0] head_s;

  // FSM and working command
  state_e            state_q, state_d;
  logic [OP_W-1:0]   work_op_q, work_op_d;
  logic [DATA_W-1:0] work_a_q, work_a_d;
  logic [DATA_W-1:0] work_b_q, work_b_d;
  logic              work_chain_q, work_chain_d;

  // Registered datapath / response controls
  logic [DATA_W-1:0] dados_q, dados_d;
  logic              en_a_q, en_a_d;
  logic              en_b_q, en_b_d;
  logic              sel_q, sel_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [1:0]        op_reg_q, op_reg_d;
  logic              rsp_valid_q, rsp_valid_d;

  assign empty_s = (count_q == {(PTR_W+1){1'b0}});
  assign full_s  = (count_q == FULL_CNT);
  assign push_s  = cmd_valid_i && !full_s;
  assign head_s  = mem_q[rd_ptr_q];

  // FIFO occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO entry storage (no reset needed; validity is tracked by count_q)
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_op_i, cmd_a_i, cmd_b_i, cmd_chain_i};
    end
  end

  // FIFO pointers and count; pointers wrap naturally since DEPTH is 2^PTR_W
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      count_q <= count_d;
    end
  end

  // Next state, working-command capture and FIFO pop
  always_comb begin
    state_d      = state_q;
    work_op_d    = work_op_q;
    work_a_d     = work_a_q;
    work_b_d     = work_b_q;
    work_chain_d = work_chain_q;
    pop_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = S_LOAD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (work_chain_q) state_d = S_EXEC;
        else              state_d = S_LOAD_B;
      end
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) begin
          // Go straight to the next command without an IDLE bubble
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = S_LOAD_A;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop_s) begin
      {work_op_d, work_a_d, work_b_d, work_chain_d} = head_s;
    end else begin
      work_chain_d = work_chain_q;
    end
  end

  // Control outputs are decoded from the next state so they appear registered
  // in the cycle that the FSM occupies that state
  always_comb begin
    dados_d     = {DATA_W{1'b0}};
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    sel_d       = 1'b0;
    op_d        = {OP_W{1'b0}};
    op_reg_d    = 2'b00;
    rsp_valid_d = 1'b0;
    case (state_d)
      S_LOAD_A: begin
        dados_d = work_a_d;
        en_a_d  = 1'b1;
      end
      S_LOAD_B: begin
        dados_d = work_b_d;
        en_b_d  = 1'b1;
      end
      S_EXEC: begin
        op_d     = work_op_d;
        sel_d    = work_chain_d;
        op_reg_d = 2'b01;
      end
      S_RESP:  rsp_valid_d = 1'b1;
      default: rsp_valid_d = 1'b0;
    endcase
  end

  // FSM state, working command and registered control outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      work_op_q    <= {OP_W{1'b0}};
      work_a_q     <= {DATA_W{1'b0}};
      work_b_q     <= {DATA_W{1'b0}};
      work_chain_q <= 1'b0;
      dados_q      <= {DATA_W{1'b0}};
      en_a_q       <= 1'b0;
      en_b_q       <= 1'b0;
      sel_q        <= 1'b0;
      op_q         <= {OP_W{1'b0}};
      op_reg_q     <= 2'b00;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_op_q    <= work_op_d;
      work_a_q     <= work_a_d;
      work_b_q     <= work_b_d;
      work_chain_q <= work_chain_d;
      dados_q      <= dados_d;
      en_a_q       <= en_a_d;
      en_b_q       <= en_b_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      op_reg_q     <= op_reg_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign cmd_ready_o  = !full_s;
  assign dp_dados_o   = dados_q;
  assign dp_enA_o     = en_a_q;
  assign dp_enB_o     = en_b_q;
  assign dp_sel_o     = sel_q;
  assign dp_op_o      = op_q;
  assign dp_op_reg_o  = op_reg_q;
  assign rsp_valid_o  = rsp_valid_q;
  // regC is held during RESP, so the passthrough is stable through a stall
  assign rsp_result_o = rsp_valid_q ? dp_result_i : {(DATA_W+1){1'b0}};
  assign busy_o       = (state_q != S_IDLE) || !empty_s;
  assign state_o      = state_q;

`ifdef CALC_SEQ_STATS_EN
  logic [7:0] stat_done_q;

  // Completed-response counter, wraps 255 -> 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_done_q <= 8'd0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      stat_done_q <= stat_done_q + 8'd1;
    end else begin
      stat_done_q <= stat_done_q;
    end
  end

  assign stat_done_o = stat_done_q;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] dp_dados;
  logic       dp_enA, dp_enB, dp_sel;
  logic [1:0] dp_op, dp_op_reg;
  logic [4:0] dp_result;
  logic       rsp_valid, rsp_ready;
  logic [4:0] rsp_result;
  logic       busy;
  logic [2:0] state;
`ifdef CALC_SEQ_STATS_EN
  logic [7:0] stat_done;
`endif

  calc_op_sequencer #(.DEPTH(4), .DATA_W(4), .OP_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_chain_i(cmd_chain),
    .dp_dados_o(dp_dados), .dp_enA_o(dp_enA), .dp_enB_o(dp_enB), .dp_sel_o(dp_sel),
    .dp_op_o(dp_op), .dp_op_reg_o(dp_op_reg), .dp_result_i(dp_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .busy_o(busy), .state_o(state)
`ifdef CALC_SEQ_STATS_EN
    , .stat_done_o(stat_done)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: op 00 A+B, 01 A-B, 10 A&B, 11 A^B, 5-bit result
  logic [3:0] reg_a, reg_b;
  logic [4:0] reg_c, alu_b, alu_y;
  always_comb begin
    alu_b = dp_sel ? reg_c : {1'b0, reg_b};
    case (dp_op)
      2'b00:   alu_y = {1'b0, reg_a} + alu_b;
      2'b01:   alu_y = {1'b0, reg_a} - alu_b;
      2'b10:   alu_y = {1'b0, reg_a} & alu_b;
      default: alu_y = {1'b0, reg_a} ^ alu_b;
    endcase
  end
  always @(posedge clk) begin
    if (rst) begin
      reg_a <= 4'd0; reg_b <= 4'd0; reg_c <= 5'd0;
    end else begin
      if (dp_enA) reg_a <= dp_dados;
      if (dp_enB) reg_b <= dp_dados;
      if (dp_op_reg == 2'b01) reg_c <= alu_y;
      else if (dp_op_reg == 2'b10) reg_c <= 5'd0;
    end
  end
  assign dp_result = reg_c;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  int t_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every completed response is compared with the scoreboard head
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      t_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: got result %0d with no command expected", rsp_result);
      end else begin
        check("rsp_result", int'(rsp_result), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ch, input bit want, input logic [4:0] exp);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      $display("FAIL push_timeout: cmd_ready stayed 0, required 1");
    end else if (want) begin
      exp_q.push_back(exp);
    end
  endtask

  task automatic next_neg();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL idle_timeout: busy still %0d, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  logic [4:0] held;
  int         seen;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_chain = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_ctrl", int'({rsp_valid, dp_enA, dp_enB, dp_sel, dp_op, dp_op_reg, dp_dados}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: 5+7, sequence and 4-edge latency
    push(2'b00, 4'd5, 4'd7, 1'b0, 1'b1, 5'd12);
    next_neg();
    check("t1_e1_state", int'(state), 1);
    check("t1_e1_loada", int'({dp_enA, dp_enB, dp_dados}), int'({1'b1, 1'b0, 4'd5}));
    next_neg();
    check("t1_e2_state", int'(state), 2);
    check("t1_e2_loadb", int'({dp_enA, dp_enB, dp_dados}), int'({1'b0, 1'b1, 4'd7}));
    next_neg();
    check("t1_e3_exec", int'({state, dp_op_reg, dp_sel, rsp_valid}), int'({3'd3, 2'b01, 1'b0, 1'b0}));
    next_neg();
    check("t1_e4_rsp", int'({state, rsp_valid, dp_op_reg}), int'({3'd4, 1'b1, 2'b00}));
    wait_idle();

    // Test 2: chain 3 + regC(12), 3-edge latency, regB never loaded
    push(2'b00, 4'd3, 4'd9, 1'b1, 1'b1, 5'd15);
    next_neg();
    check("t2_e1", int'({state, dp_enA, dp_enB, dp_dados}), int'({3'd1, 1'b1, 1'b0, 4'd3}));
    next_neg();
    check("t2_e2", int'({state, dp_enB, dp_sel, dp_op_reg}), int'({3'd3, 1'b0, 1'b1, 2'b01}));
    next_neg();
    check("t2_e3", int'({state, rsp_valid, dp_enB}), int'({3'd4, 1'b1, 1'b0}));
    wait_idle();

    // Test 3: overflow into bit 4
    push(2'b00, 4'd15, 4'd15, 1'b0, 1'b1, 5'b11110);
    wait_idle();

    // Test 4: fill with stalled response, then drain in order 4 cycles apart
    rsp_ready = 1'b0;
    push(2'b00, 4'd1,  4'd2,  1'b0, 1'b1, 5'd3);
    push(2'b01, 4'd9,  4'd4,  1'b0, 1'b1, 5'd5);
    push(2'b10, 4'd12, 4'd10, 1'b0, 1'b1, 5'd8);
    push(2'b11, 4'd6,  4'd3,  1'b0, 1'b1, 5'd5);
    push(2'b00, 4'd8,  4'd8,  1'b0, 1'b1, 5'd16);
    @(negedge clk);
    check("t4_full", int'(cmd_ready), 0);
    check("t4_resp_state", int'({state, rsp_valid}), int'({3'd4, 1'b1}));
    held = rsp_result;
    check("t4_held_value", int'(held), 3);
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check("t4_stall_stable", int'({rsp_valid, rsp_result}), int'({1'b1, held}));
      check("t4_stall_nowrite", int'({dp_enA, dp_enB, dp_op_reg}), 0);
    end
    @(posedge clk); #1;
    t_q.delete();
    rsp_ready = 1'b1;
    wait_idle();
    check("t4_count", t_q.size(), 5);
    for (int i = 1; i < t_q.size(); i++) check("t4_gap", t_q[i] - t_q[i-1], 4);

    // Test 5: reset in LOAD_B with 2 queued discards everything
    push(2'b00, 4'd1, 4'd1, 1'b0, 1'b0, 5'd0);
    push(2'b00, 4'd2, 4'd2, 1'b0, 1'b0, 5'd0);
    push(2'b00, 4'd3, 4'd3, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("t5_in_loadb", int'(state), 2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_state", int'(state), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_ctrl", int'({dp_enA, dp_enB, dp_op_reg, rsp_valid, cmd_ready}), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      next_neg();
      if (rsp_valid || busy) seen++;
    end
    check("t5_no_rsp", seen, 0);

    // Chain right after reset uses regC=0
    @(posedge clk); #1;
    push(2'b00, 4'd6, 4'd0, 1'b1, 1'b1, 5'd6);
    wait_idle();

`ifdef CALC_SEQ_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 257; i++) push(2'b00, 4'd1, 4'd2, 1'b0, 1'b1, 5'd3);
    wait_idle();
    check("t6_stat_done", int'(stat_done), 1);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
